// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between N byte-stream requesters.
// A requester keeps the grant for a whole packet, or until it stalls longer than HOLD_TICKS.
module uart_tx_arbiter #(
  parameter int N          = 4,
  parameter int HOLD_TICKS = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_valid,
  input  logic [8*N-1:0]   req_data,
  input  logic [N-1:0]     req_last,
  output logic [N-1:0]     req_ready,
  output logic             tx_start,
  output logic [7:0]       tx_din,
  input  logic             tx_done_tick,
  output logic [N-1:0]     grant,
  output logic             busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, START, WAIT} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic [PW-1:0] sel_idx;
  logic [PW-1:0] cand;
  logic [PW-1:0] next_ptr;
  logic          sel_found;
  logic          last_r;
  logic [CW-1:0] hold_cnt;
  logic          xfer;
  logic          timeout;
  logic [7:0]    data_arr [N];

  always_comb begin
    for (int unsigned k = 0; k < N; k++) begin
      data_arr[k] = req_data[8*k +: 8];
    end
  end

  // Scan from ptr upward, wrapping, so the requester served last has lowest priority.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = PW'((32'(ptr) + k) % N);
      if (!sel_found && req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == ISSUE) begin
      req_ready[gidx] = req_valid[gidx];
    end
  end

  assign next_ptr = (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;
  assign xfer     = (state == ISSUE) && req_valid[gidx];
  assign timeout  = (HOLD_TICKS != 0) && (int'(hold_cnt) == HOLD_TICKS - 1);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      ptr      <= '0;
      gidx     <= '0;
      tx_din   <= '0;
      tx_start <= 1'b0;
      last_r   <= 1'b0;
      hold_cnt <= '0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_found) begin
            gidx     <= sel_idx;
            grant    <= N'(1) << sel_idx;
            hold_cnt <= '0;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (xfer) begin
            tx_din   <= data_arr[gidx];
            last_r   <= req_last[gidx];
            tx_start <= 1'b1;
            state    <= START;
          end else if (timeout) begin
            state <= IDLE;
            ptr   <= next_ptr;
            grant <= '0;
          end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        START: begin
          state <= WAIT;
        end
        WAIT: begin
          if (tx_done_tick) begin
            if (last_r) begin
              state <= IDLE;
              ptr   <= next_ptr;
              grant <= '0;
            end else begin
              state    <= ISSUE;
              hold_cnt <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
